// File: rtl/bht_predict_ctrl.sv
// Fetch-side 2-bit saturating branch history table with F->D->E prediction tracking
// and E-stage mispredict/recovery. Optional statistics counters under `BHT_STATS_EN.
module bht_predict_ctrl #(
    parameter int unsigned IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PCF,
    input  logic        BtbHitF,
    input  logic [31:0] BtbTargetF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        StallE,
    input  logic        FlushE,
    input  logic [31:0] PCE,
    input  logic        BrInstrE,
    input  logic        BranchE,
    input  logic [31:0] BrNPC,
    output logic        PredTakenF,
    output logic [31:0] NPCPredF,
    output logic        MispredictE,
    output logic [31:0] RecoverPCE
`ifdef BHT_STATS_EN
    ,
    output logic [31:0] BrCount,
    output logic [31:0] MissCount
`endif
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [1:0]       cnt_q [DEPTH];
    logic [1:0]       cnt_cur;
    logic [1:0]       cnt_d;
    logic [IDX_W-1:0] idx_f;
    logic [IDX_W-1:0] idx_e;
    logic             upd_e;

    logic             pred_taken_d_q;
    logic [31:0]      pred_target_d_q;
    logic             pred_taken_e_q;
    logic [31:0]      pred_target_e_q;
    logic [31:0]      pc_plus4_e;

    assign idx_f = PCF[IDX_W+1:2];
    assign idx_e = PCE[IDX_W+1:2];
    assign upd_e = BrInstrE & ~FlushE;

    // F-stage prediction reads the table without bypassing a same-cycle E update
    assign PredTakenF = BtbHitF & cnt_q[idx_f][1];
    assign NPCPredF   = PredTakenF ? BtbTargetF : PCF + 32'd4;

    always_comb begin
        cnt_cur = cnt_q[idx_e];
        cnt_d   = cnt_cur;
        if (BranchE) begin
            if (cnt_cur != 2'b11) cnt_d = cnt_cur + 2'd1;
        end else begin
            if (cnt_cur != 2'b00) cnt_d = cnt_cur - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) cnt_q[i] <= 2'b01;
        end else if (upd_e) begin
            cnt_q[idx_e] <= cnt_d;
        end
    end

    // Prediction travels with the instruction; flush beats stall in each stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_taken_d_q  <= 1'b0;
            pred_target_d_q <= 32'd0;
            pred_taken_e_q  <= 1'b0;
            pred_target_e_q <= 32'd0;
        end else begin
            if (FlushD) begin
                pred_taken_d_q  <= 1'b0;
                pred_target_d_q <= 32'd0;
            end else if (!StallD) begin
                pred_taken_d_q  <= PredTakenF;
                pred_target_d_q <= NPCPredF;
            end
            if (FlushE) begin
                pred_taken_e_q  <= 1'b0;
                pred_target_e_q <= 32'd0;
            end else if (!StallE) begin
                pred_taken_e_q  <= pred_taken_d_q;
                pred_target_e_q <= pred_target_d_q;
            end
        end
    end

    assign pc_plus4_e = PCE + 32'd4;

    // A predicted-taken non-branch is a stale BTB alias and must also redirect
    always_comb begin
        MispredictE = 1'b0;
        RecoverPCE  = pc_plus4_e;
        if (BrInstrE && BranchE) begin
            if (!pred_taken_e_q || (pred_target_e_q != BrNPC)) begin
                MispredictE = 1'b1;
                RecoverPCE  = BrNPC;
            end
        end else if (pred_taken_e_q) begin
            MispredictE = 1'b1;
        end
    end

`ifdef BHT_STATS_EN
    logic [31:0] br_count_q;
    logic [31:0] miss_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_q   <= 32'd0;
            miss_count_q <= 32'd0;
        end else if (!FlushE) begin
            if (BrInstrE)    br_count_q   <= br_count_q + 32'd1;
            if (MispredictE) miss_count_q <= miss_count_q + 32'd1;
        end
    end

    assign BrCount   = br_count_q;
    assign MissCount = miss_count_q;
`endif

endmodule
